// File: rtl/count_seg_scan.sv
// Four-slot multiplexed seven-segment driver for the up/down counter pair, with an anode guard interval and a frame strobe.
// Build option: define SEG_BCD_EN to show decimal units/tens; otherwise hex units with blank tens slots.
module count_seg_scan #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] up_count,
  input  logic [3:0] down_count,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  localparam int unsigned   DW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF   = ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {S0, S1, S2, S3} slot_t;

  slot_t         slot, slot_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic          wrap;
  logic [3:0]    snap_up, snap_dn;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          ft_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Freeze sampled on the same edge as the data, so a freeze rise keeps the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_up <= '0;
      snap_dn <= '1;
    end else if (!freeze) begin
      snap_up <= up_count;
      snap_dn <= down_count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      slot    <= S0;
    end else begin
      div_cnt <= div_nxt;
      slot    <= slot_nxt;
    end
  end

  always_comb begin
    wrap     = (div_cnt == DIV_LAST);
    div_nxt  = wrap ? '0 : div_cnt + 1'b1;
    slot_nxt = slot;
    if (wrap) begin
      case (slot)
        S0:      slot_nxt = S1;
        S1:      slot_nxt = S2;
        S2:      slot_nxt = S3;
        default: slot_nxt = S0;
      endcase
    end
  end

`ifdef SEG_BCD_EN
  logic       up_ge10, dn_ge10;
  logic [3:0] up_units, dn_units;
  always_comb begin
    up_ge10  = (snap_up >= 4'd10);
    dn_ge10  = (snap_dn >= 4'd10);
    up_units = up_ge10 ? snap_up - 4'd10 : snap_up;
    dn_units = dn_ge10 ? snap_dn - 4'd10 : snap_dn;
  end
`endif

  always_comb begin
    seg_nxt = '0;
    an_nxt  = '0;
    case (slot)
`ifdef SEG_BCD_EN
      S0:      seg_nxt = hex7(up_units);
      S1:      seg_nxt = up_ge10 ? hex7(4'd1) : '0;
      S2:      seg_nxt = hex7(dn_units);
      default: seg_nxt = dn_ge10 ? hex7(4'd1) : '0;
`else
      S0:      seg_nxt = hex7(snap_up);
      S2:      seg_nxt = hex7(snap_dn);
      default: seg_nxt = '0;
`endif
    endcase
    if (32'(div_cnt) >= GUARD) begin
      case (slot)
        S0:      an_nxt = 4'b0001;
        S1:      an_nxt = 4'b0010;
        S2:      an_nxt = 4'b0100;
        default: an_nxt = 4'b1000;
      endcase
    end
    ft_nxt = wrap && (slot == S3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ {7{ACTIVE_LOW}};
      an         <= an_nxt ^ {4{ACTIVE_LOW}};
      digit_sel  <= slot;
      frame_tick <= ft_nxt;
    end
  end

endmodule

// File: tb/tb_count_seg_scan.sv
// Directed bench for count_seg_scan: an active-high and an active-low instance share all stimulus.
module tb_count_seg_scan;

  localparam int unsigned RD = 8;
  localparam int unsigned GD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] up_count = 4'h0;
  logic [3:0] down_count = 4'hF;
  logic       freeze = 1'b0;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic [1:0] sel0, sel1;
  logic       ft0, ft1;

  int checks = 0;
  int failures = 0;

  count_seg_scan #(.REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset(reset), .up_count(up_count), .down_count(down_count),
    .freeze(freeze), .seg(seg0), .an(an0), .digit_sel(sel0), .frame_tick(ft0));

  count_seg_scan #(.REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .up_count(up_count), .down_count(down_count),
    .freeze(freeze), .seg(seg1), .an(an1), .digit_sel(sel1), .frame_tick(ft1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " an0"},  8'(an0),  8'h00);
    check({tag, " seg0"}, 8'(seg0), 8'h00);
    check({tag, " sel0"}, 8'(sel0), 8'h00);
    check({tag, " ft0"},  8'(ft0),  8'h00);
    check({tag, " an1"},  8'(an1),  8'h0F);
    check({tag, " seg1"}, 8'(seg1), 8'h7F);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_idle("rst");
    reset = 1'b0;
  endtask

  // k = clock edges since reset release; outputs show the state of edge k-1.
  task automatic scan_cycle(input int k, input bit chk_seg, input logic [6:0] es);
    logic [1:0] s;
    logic [3:0] a, a_n;
    logic [6:0] es_n;
    logic       f;
    tick();
    s    = 2'(((k - 1) / RD) % 4);
    a    = (((k - 1) % RD) < GD) ? 4'b0000 : (4'b0001 << s);
    a_n  = ~a;
    es_n = ~es;
    f    = (k % (4 * RD) == 0);
    check($sformatf("sel0 k=%0d", k), 8'(sel0), 8'(s));
    check($sformatf("an0 k=%0d", k),  8'(an0),  8'(a));
    check($sformatf("ft0 k=%0d", k),  8'(ft0),  8'(f));
    check($sformatf("sel1 k=%0d", k), 8'(sel1), 8'(s));
    check($sformatf("an1 k=%0d", k),  8'(an1),  8'(a_n));
    check($sformatf("ft1 k=%0d", k),  8'(ft1),  8'(f));
    if (chk_seg) begin
      check($sformatf("seg0 k=%0d", k), 8'(seg0), 8'(es));
      check($sformatf("seg1 k=%0d", k), 8'(seg1), 8'(es_n));
    end
  endtask

  task automatic run_frame(input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 1; k <= 5 * RD; k++)
      scan_cycle(k, k >= 3, e[((k - 1) / RD) % 4]);
  endtask

  initial begin
    // up=0, dn=F; frame includes the slot sequence and the single frame strobe
    up_count = 4'h0; down_count = 4'hF; freeze = 1'b0;
    do_reset();
`ifdef SEG_BCD_EN
    run_frame(7'h3F, 7'h00, 7'h6D, 7'h06);
`else
    run_frame(7'h3F, 7'h00, 7'h71, 7'h00);
`endif

    up_count = 4'd13; down_count = 4'd7;
    do_reset();
`ifdef SEG_BCD_EN
    run_frame(7'h4F, 7'h06, 7'h07, 7'h00);
`else
    run_frame(7'h5E, 7'h00, 7'h07, 7'h00);
`endif

    // freeze rises together with the input change: 5 is held
    up_count = 4'd5; down_count = 4'd0;
    do_reset();
    scan_cycle(1, 1'b0, 7'h00);
    scan_cycle(2, 1'b1, 7'h6D);
    freeze = 1'b1; up_count = 4'd9;
    for (int k = 3; k <= 66; k++)
      scan_cycle(k, ((k - 1) / RD) % 4 == 0, 7'h6D);
    freeze = 1'b0;
    scan_cycle(67, 1'b1, 7'h6D);
    scan_cycle(68, 1'b1, 7'h6F);

    // asynchronous reset in the middle of slot 2
    up_count = 4'd3; down_count = 4'd4;
    do_reset();
    for (int k = 1; k <= 20; k++)
      scan_cycle(k, 1'b0, 7'h00);
    #3 reset = 1'b1;
    #1 check_idle("async");
    tick();
    reset = 1'b0;
    scan_cycle(1, 1'b1, 7'h3F);
    scan_cycle(2, 1'b1, 7'h4F);
    scan_cycle(3, 1'b1, 7'h4F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
